// File: rtl/tetris_drop_timer.sv
// Gravity scheduler: turns slow clock_b ticks into level-paced drop requests.
// Optional sticky overrun flag is built when DROP_OVERRUN_EN is defined.
module tetris_drop_timer #(
    parameter int BASE_INTERVAL = 10,
    parameter int MIN_INTERVAL  = 1,
    parameter int LEVEL_STEP    = 1,
    parameter int CNT_W         = 5
) (
    input  logic       CLOCK_50M,
    input  logic       reset,
    input  logic       clock_b,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    input  logic       soft_drop,
    input  logic [3:0] level,
    input  logic       drop_ack,
    output logic       drop_req,
    output logic       running,
    output logic       paused,
    output logic       overrun
);

    localparam int IW = CNT_W + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            drop_req_q, drop_req_d;
    logic            running_q, running_d;
    logic            paused_q, paused_d;

    logic            tick;
    logic [IW-1:0]   base_w, min_w, dec_w, interval, cnt_inc;
    logic            expire;

    assign tick = sync2_q & ~prev_q;

    // Wide arithmetic so high levels clamp instead of wrapping.
    always_comb begin
        base_w  = IW'(BASE_INTERVAL);
        min_w   = IW'(MIN_INTERVAL);
        dec_w   = IW'(level) * IW'(LEVEL_STEP);
        cnt_inc = IW'(tick_cnt_q) + IW'(1);
        if (soft_drop || (dec_w >= base_w) || ((base_w - dec_w) < min_w)) begin
            interval = min_w;
        end else begin
            interval = base_w - dec_w;
        end
    end

    assign expire = (state_q == S_RUN) && tick && (cnt_inc >= interval);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        drop_req_d = drop_req_q;

        // A simultaneous ack retires the old request while expiry raises a new one.
        if (expire) begin
            drop_req_d = 1'b1;
        end else if (drop_ack) begin
            drop_req_d = 1'b0;
        end

        if ((state_q == S_RUN) && tick) begin
            tick_cnt_d = expire ? '0 : tick_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    tick_cnt_d = '0;
                end
            end
            S_RUN:   if (pause) state_d = S_PAUSE;
            S_PAUSE: if (pause) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (game_over) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            drop_req_d = 1'b0;
        end

        running_d = (state_d == S_RUN);
        paused_d  = (state_d == S_PAUSE);
    end

    always_ff @(posedge CLOCK_50M) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            tick_cnt_q <= '0;
            drop_req_q <= 1'b0;
            running_q  <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= clock_b;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            tick_cnt_q <= tick_cnt_d;
            drop_req_q <= drop_req_d;
            running_q  <= running_d;
            paused_q   <= paused_d;
        end
    end

    assign drop_req = drop_req_q;
    assign running  = running_q;
    assign paused   = paused_q;

`ifdef DROP_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (expire && drop_req_q && !drop_ack && !game_over) overrun_d = 1'b1;
        if ((state_q == S_IDLE) && start && !game_over)      overrun_d = 1'b0;
    end

    always_ff @(posedge CLOCK_50M) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
